// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared state type, default widths and read-latency bounds for the memory/IO arbiter.
package mem_io_pkg;
    localparam int DMEM_AW_DEF = 14;
    localparam int IO_W_DEF    = 24;
    localparam int RD_LAT_MIN  = 1;
    localparam int RD_LAT_MAX  = 3;
    localparam int LAT_W       = $clog2(RD_LAT_MAX + 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;

    // More than one decoded CPU strobe at once is a protocol error
    function automatic logic strobe_conflict(input logic [3:0] s);
        return $countones(s) > 1;
    endfunction
endpackage

// File: rtl/mem_io_arbiter_if.sv
// mem_io_arbiter_if: CPU, loader, data-memory and LED/switch signals shared by the arbiter and its environment.
interface mem_io_arbiter_if
    import mem_io_pkg::*;
#(
    parameter int DMEM_AW = DMEM_AW_DEF,
    parameter int IO_W    = IO_W_DEF
);
    logic               upload_mode;
    logic               cpu_mread, cpu_mwrite, cpu_ioread, cpu_iowrite;
    logic [31:0]        cpu_addr, cpu_wdata, cpu_rdata;
    logic               cpu_stall, bus_err;
    logic               ldr_wen, ldr_ack;
    logic [DMEM_AW-1:0] ldr_addr;
    logic [31:0]        ldr_wdata;
    logic               dmem_en, dmem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [31:0]        dmem_wdata, dmem_rdata;
    logic               led_cs, sw_cs;
    logic [IO_W-1:0]    led_wdata, sw_rdata;

    modport slave (
        input  upload_mode, cpu_mread, cpu_mwrite, cpu_ioread, cpu_iowrite, cpu_addr, cpu_wdata,
               ldr_wen, ldr_addr, ldr_wdata, dmem_rdata, sw_rdata,
        output cpu_rdata, cpu_stall, bus_err, ldr_ack, dmem_en, dmem_we, dmem_addr, dmem_wdata,
               led_cs, led_wdata, sw_cs
    );

    modport master (
        output upload_mode, cpu_mread, cpu_mwrite, cpu_ioread, cpu_iowrite, cpu_addr, cpu_wdata,
               ldr_wen, ldr_addr, ldr_wdata, dmem_rdata, sw_rdata,
        input  cpu_rdata, cpu_stall, bus_err, ldr_ack, dmem_en, dmem_we, dmem_addr, dmem_wdata,
               led_cs, led_wdata, sw_cs
    );
endinterface

// File: rtl/mem_lat_counter.sv
// mem_lat_counter: loadable down-counter timing the BRAM read latency; done flags the capture cycle.
module mem_lat_counter
    import mem_io_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [LAT_W-1:0] load_val,
    output logic             done
);
    logic [LAT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && cnt != '0) cnt <= cnt - LAT_W'(1);

    assign done = cnt == LAT_W'(1);
endmodule

// File: rtl/mem_io_arbiter.sv
// mem_io_arbiter: shares the data-memory port and LED/switch selects between the CPU and the UART loader,
// stalling the CPU across synchronous BRAM read latency.
module mem_io_arbiter
    import mem_io_pkg::*;
#(
    parameter int DMEM_AW = DMEM_AW_DEF,
    parameter int RD_LAT  = 1,
    parameter int IO_W    = IO_W_DEF
) (
    input logic             clk,
    input logic             rst_n,
    mem_io_arbiter_if.slave bus
);
    state_t             state;
    logic [31:0]        rdata_q;
    logic [IO_W-1:0]    led_q;
    logic [DMEM_AW-1:0] addr_q, cpu_word;
    logic               err_q, ack_q, lat_done;
    logic               idle, in_wait, ldr_go, cpu_sel, conflict;
    logic               do_mr, do_mw, do_ir, do_iw;
    logic               unused_addr_bits;

    assign cpu_word         = bus.cpu_addr[DMEM_AW+1:2];
    assign unused_addr_bits = ^{bus.cpu_addr[31:DMEM_AW+2], bus.cpu_addr[1:0]};

    // Every combinational output is gated by rst_n so reset silences the bus without a clock
    always_comb begin
        idle     = rst_n && state == IDLE;
        in_wait  = rst_n && state == RD_WAIT;
        ldr_go   = idle && bus.upload_mode && bus.ldr_wen;
        cpu_sel  = idle && !bus.upload_mode;
        conflict = strobe_conflict({bus.cpu_mread, bus.cpu_mwrite, bus.cpu_ioread, bus.cpu_iowrite});
        do_mr    = cpu_sel && !conflict && bus.cpu_mread;
        do_mw    = cpu_sel && !conflict && bus.cpu_mwrite;
        do_ir    = cpu_sel && !conflict && bus.cpu_ioread;
        do_iw    = cpu_sel && !conflict && bus.cpu_iowrite;
        bus.dmem_en    = ldr_go || do_mr || do_mw || in_wait;
        bus.dmem_we    = ldr_go || do_mw;
        bus.dmem_addr  = ldr_go ? bus.ldr_addr : (do_mr || do_mw) ? cpu_word : in_wait ? addr_q : '0;
        bus.dmem_wdata = ldr_go ? bus.ldr_wdata : do_mw ? bus.cpu_wdata : '0;
        bus.cpu_stall  = (idle && bus.upload_mode) || do_mr || in_wait;
        bus.cpu_rdata  = do_ir ? 32'(bus.sw_rdata) : rdata_q;
        bus.led_cs     = do_iw;
        bus.sw_cs      = do_ir;
        bus.led_wdata  = led_q;
        bus.bus_err    = err_q;
        bus.ldr_ack    = ack_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            rdata_q <= '0;
            led_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= ldr_go;
            err_q <= err_q || (cpu_sel && conflict);
            if (do_iw) led_q <= bus.cpu_wdata[IO_W-1:0];
            if (do_mr) addr_q <= cpu_word;
            if (state == RD_WAIT && lat_done) rdata_q <= bus.dmem_rdata;
            state <= do_mr ? RD_WAIT :
                     (state == RD_WAIT && lat_done) ? RD_DONE :
                     state == RD_DONE ? IDLE : state;
        end

    mem_lat_counter u_lat (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (do_mr),
        .dec      (state == RD_WAIT),
        .load_val (LAT_W'(RD_LAT)),
        .done     (lat_done)
    );
endmodule

// File: tb/tb_mem_io_arbiter.sv
// tb_mem_io_arbiter: vector table for single-cycle CPU accesses plus scoreboarded reads and loader/error/reset sequences.
module tb_mem_io_arbiter;
    import mem_io_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic [31:0] mem [0:63];
    logic [31:0] exp_q [$];

    typedef struct {
        logic        mr, mw, ir, iw;
        logic [31:0] addr, wdata;
        logic [23:0] sw;
        logic        en, we, lcs, scs, stall;
        logic [13:0] daddr;
        logic [31:0] dwdata, rdata;
        logic [23:0] led;
    } vec_t;
    vec_t vt [5];

    mem_io_arbiter_if #(.DMEM_AW(14), .IO_W(24)) bus ();
    mem_io_arbiter #(.DMEM_AW(14), .RD_LAT(1), .IO_W(24)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Synchronous BRAM with one cycle of read latency
    always @(posedge clk)
        if (bus.dmem_en) begin
            if (bus.dmem_we) mem[bus.dmem_addr[5:0]] <= bus.dmem_wdata;
            bus.dmem_rdata <= mem[bus.dmem_addr[5:0]];
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        chk(name, 32'(act), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.upload_mode = 1'b0;
        bus.cpu_mread = 1'b0;
        bus.cpu_mwrite = 1'b0;
        bus.cpu_ioread = 1'b0;
        bus.cpu_iowrite = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_wdata = '0;
        bus.ldr_wen = 1'b0;
        bus.ldr_addr = '0;
        bus.ldr_wdata = '0;
        bus.sw_rdata = '0;
    endtask

    // Issues a CPU load, pushes the expected word, and pops/compares when the stall drops
    task automatic cpu_read(input string tag, input logic [31:0] addr, input logic [31:0] exp, input logic up_in_wait);
        int n = 0;
        bus.cpu_mread = 1'b1;
        bus.cpu_addr = addr;
        #2;
        chkb({tag, " issue en"}, bus.dmem_en, 1'b1);
        chkb({tag, " issue we"}, bus.dmem_we, 1'b0);
        chk({tag, " issue addr"}, 32'(bus.dmem_addr), addr >> 2);
        exp_q.push_back(exp);
        while (bus.cpu_stall && n < 10) begin
            tick();
            if (up_in_wait && n == 0) begin
                bus.upload_mode = 1'b1;
                bus.ldr_wen = 1'b1;
                bus.ldr_addr = 14'd5;
                bus.ldr_wdata = 32'h55;
            end
            #2;
            n++;
            if (bus.cpu_stall) chk({tag, " wait addr"}, 32'(bus.dmem_addr), addr >> 2);
            chkb({tag, " no write"}, bus.dmem_we, 1'b0);
        end
        chk({tag, " stall cycles"}, 32'(n), 32'd2);
        chkb({tag, " no reissue"}, bus.dmem_en, 1'b0);
        if (exp_q.size() == 0) chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
        else chk({tag, " rdata"}, bus.cpu_rdata, exp_q.pop_front());
        bus.cpu_mread = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        clear_in();
        vt[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h12345678, 24'h0,
                  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 14'd2, 32'h12345678, 32'h0, 24'h0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 24'h0,
                  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 14'd4, 32'hDEADBEEF, 32'h0, 24'h0};
        vt[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hAB00FF11, 24'h0,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 14'd0, 32'h0, 32'h0, 24'h00FF11};
        vt[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 24'hA5A5A5,
                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 14'd0, 32'h0, 32'h00A5A5A5, 24'h00FF11};
        vt[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 24'hA5A5A5,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 32'h0, 32'h0, 24'h00FF11};

        #2;
        chkb("reset stall", bus.cpu_stall, 1'b0);
        chkb("reset dmem_en", bus.dmem_en, 1'b0);
        chkb("reset ack", bus.ldr_ack, 1'b0);
        chkb("reset err", bus.bus_err, 1'b0);
        chk("reset rdata", bus.cpu_rdata, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        foreach (vt[i]) begin
            bus.cpu_mread = vt[i].mr;
            bus.cpu_mwrite = vt[i].mw;
            bus.cpu_ioread = vt[i].ir;
            bus.cpu_iowrite = vt[i].iw;
            bus.cpu_addr = vt[i].addr;
            bus.cpu_wdata = vt[i].wdata;
            bus.sw_rdata = vt[i].sw;
            #2;
            chkb($sformatf("vec%0d en", i), bus.dmem_en, vt[i].en);
            chkb($sformatf("vec%0d we", i), bus.dmem_we, vt[i].we);
            chk($sformatf("vec%0d addr", i), 32'(bus.dmem_addr), 32'(vt[i].daddr));
            chk($sformatf("vec%0d wdata", i), bus.dmem_wdata, vt[i].dwdata);
            chkb($sformatf("vec%0d led_cs", i), bus.led_cs, vt[i].lcs);
            chkb($sformatf("vec%0d sw_cs", i), bus.sw_cs, vt[i].scs);
            chkb($sformatf("vec%0d stall", i), bus.cpu_stall, vt[i].stall);
            chk($sformatf("vec%0d rdata", i), bus.cpu_rdata, vt[i].rdata);
            tick();
            chk($sformatf("vec%0d led_wdata", i), 32'(bus.led_wdata), 32'(vt[i].led));
        end
        clear_in();

        cpu_read("rd10", 32'h10, 32'hDEADBEEF, 1'b0);
        cpu_read("rd08", 32'h8, 32'h12345678, 1'b0);

        // Loader burst; a stray CPU iowrite must be ignored
        bus.upload_mode = 1'b1;
        bus.cpu_iowrite = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ldr_wen = 1'b1;
            bus.ldr_addr = 14'(i);
            bus.ldr_wdata = 32'h100 + 32'(i);
            #2;
            chkb($sformatf("ldr%0d we", i), bus.dmem_en & bus.dmem_we, 1'b1);
            chk($sformatf("ldr%0d addr", i), 32'(bus.dmem_addr), 32'(i));
            chk($sformatf("ldr%0d wdata", i), bus.dmem_wdata, 32'h100 + 32'(i));
            chkb($sformatf("ldr%0d stall", i), bus.cpu_stall, 1'b1);
            chkb($sformatf("ldr%0d led_cs", i), bus.led_cs, 1'b0);
            chkb($sformatf("ldr%0d ack", i), bus.ldr_ack, i > 0);
            tick();
        end
        bus.ldr_wen = 1'b0;
        #2;
        chkb("ldr last ack", bus.ldr_ack, 1'b1);
        chkb("ldr idle stall", bus.cpu_stall, 1'b1);
        chkb("ldr idle en", bus.dmem_en, 1'b0);
        tick();
        #2;
        chkb("ldr ack low", bus.ldr_ack, 1'b0);
        clear_in();
        tick();

        cpu_read("rd04", 32'h4, 32'h101, 1'b0);
        cpu_read("rd08b", 32'h8, 32'h102, 1'b1);
        #2;
        chkb("late ldr we", bus.dmem_we, 1'b1);
        chk("late ldr addr", 32'(bus.dmem_addr), 32'd5);
        chkb("late ldr no early ack", bus.ldr_ack, 1'b0);
        tick();
        bus.upload_mode = 1'b0;
        #2;
        chkb("late ldr ack", bus.ldr_ack, 1'b1);
        chkb("ldr ignored on fall", bus.dmem_we, 1'b0);
        chkb("no stall on fall", bus.cpu_stall, 1'b0);
        tick();
        #2;
        chkb("no ack outside upload", bus.ldr_ack, 1'b0);
        clear_in();
        tick();
        cpu_read("rd14", 32'h14, 32'h55, 1'b0);

        // Conflicting strobes
        bus.cpu_mread = 1'b1;
        bus.cpu_iowrite = 1'b1;
        bus.cpu_addr = 32'h10;
        bus.cpu_wdata = 32'h00123456;
        #2;
        chkb("conflict en", bus.dmem_en, 1'b0);
        chkb("conflict led_cs", bus.led_cs, 1'b0);
        chkb("conflict stall", bus.cpu_stall, 1'b0);
        tick();
        clear_in();
        #2;
        chkb("conflict err", bus.bus_err, 1'b1);
        chk("conflict led held", 32'(bus.led_wdata), 32'h00FF11);
        tick();
        tick();
        chkb("err sticky", bus.bus_err, 1'b1);

        // Asynchronous reset in the middle of a read
        bus.cpu_mread = 1'b1;
        bus.cpu_addr = 32'h10;
        tick();
        #2;
        chkb("pre-reset stall", bus.cpu_stall, 1'b1);
        rst_n = 1'b0;
        #1;
        chkb("midrd reset stall", bus.cpu_stall, 1'b0);
        chkb("midrd reset en", bus.dmem_en, 1'b0);
        chkb("midrd reset err", bus.bus_err, 1'b0);
        chk("midrd reset rdata", bus.cpu_rdata, 32'h0);
        chk("midrd reset led", 32'(bus.led_wdata), 32'h0);
        bus.cpu_mread = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        #2;
        chkb("post-reset idle stall", bus.cpu_stall, 1'b0);
        chkb("post-reset idle en", bus.dmem_en, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
